div_unit_sequencer: RTL and testbench
=====================================

// Module: div_unit_sequencer
// PURPOSE
//  Multi-cycle controller for the RV32M divide ops DIV/DIVU/REM/REMU in the EX stage.
//  Runs a radix-2 restoring divider: one quotient bit per cycle, then a sign-fix cycle.
//  Raises BUSY so the pipeline control unit stalls IF/ID/EX while the divide runs.
//  Resolves the divide-by-zero and signed-overflow cases in one cycle.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; one iteration per bit
//  CNT_WIDTH   5   iteration counter width, equal to log2(DATA_WIDTH)
// PORTS
//  CLK      in   1           rising-edge clock
//  RESET    in   1           synchronous, active-low reset
//  START    in   1           request a divide; sampled in IDLE or DONE state only
//  DIV_SEL  in   2           00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with START
//  DATA1    in   DATA_WIDTH  dividend (rs1); captured with START
//  DATA2    in   DATA_WIDTH  divisor (rs2); captured with START
//  FLUSH    in   1           abort the in-flight op (branch/jump flush)
//  BUSY     out  1           stall request to pipeline control
//  DONE     out  1           one-cycle pulse: RESULT is valid this cycle
//  RESULT   out  DATA_WIDTH  quotient or remainder; holds until the next completion
// BEHAVIOUR
//  Reset (RESET=0 at an edge): state=IDLE; BUSY=0, DONE=0, RESULT=0; counter and working regs=0.
//  RESET has priority over FLUSH, and FLUSH has priority over START.
//  States: IDLE, CALC, FIX, DONE. BUSY=1 only in CALC and FIX. DONE=1 only in DONE state.
//  IDLE/DONE + START at edge E0:
//   - Capture the operands and DIV_SEL.
//   - DATA2==0: RESULT = all-ones (DIV/DIVU) or DATA1 (REM/REMU); next state is DONE.
//   - Signed op (DIV/REM) with DATA1=0x80000000 and DATA2=0xFFFFFFFF: RESULT = 0x80000000 (DIV) or 0 (REM); next state is DONE.
//   - Otherwise: load |DATA1| and |DATA2| (magnitudes only for DIV/REM; raw values for DIVU/REMU), clear the remainder, counter=0; next state is CALC.
//  DONE state with no START: next state is IDLE. With START: treated exactly as IDLE (back-to-back ops).
//  CALC, each edge, one restoring iteration:
//   - rem = {rem[W-2:0], dvd[W-1]}; dvd <<= 1.
//   - If rem >= divisor (unsigned compare): rem -= divisor and quotient LSB = 1; else quotient LSB = 0.
//   - counter++. After the edge where counter==DATA_WIDTH-1 (32 iterations total), next state is FIX.
//  FIX, one edge:
//   - Quotient is negated if the op is signed and sign(DATA1)^sign(DATA2)=1.
//   - Remainder is negated if the op is signed and sign(DATA1)=1.
//   - The selected value is registered into RESULT; next state is DONE.
//  Latency:
//   - Normal path: START sampled at E0; DONE high in the cycle after E33 (34 cycles); BUSY high for 33 cycles.
//   - Special case: DONE high in the cycle after E0; BUSY never asserted.
//  START is ignored in CALC and FIX; no queuing.
//  FLUSH=1 at any edge: next state is IDLE; the aborted op never pulses DONE; RESULT keeps its last value; START that cycle is dropped.
//  Unsigned ops never take the overflow path (DIVU 0x80000000/0xFFFFFFFF = 0 via CALC).
//  Every output is registered; no combinational path from any input to an output.
// TESTING
//  1. DIVU 100/7 -> BUSY=1 for 33 cycles, DONE pulse 34 cycles after START, RESULT=14; REMU 100/7 -> 2.
//  2. DIV -100/7 -> 0xFFFFFFF2; REM -100/7 -> 0xFFFFFFFE; DIV 100/-7 -> 0xFFFFFFF2; REM 100/-7 -> 2.
//  3. DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, DONE the cycle after START, BUSY stays 0.
//  4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle; REM -> 0; DIVU same operands -> 0 after 34 cycles.
//  5. FLUSH 10 cycles into DIVU 100/7 -> IDLE next cycle, no DONE, RESULT unchanged; START held high through DONE back-to-back -> second op accepted in the DONE cycle.
//  6. RESET=0 at cycle 5 of an op -> next edge BUSY=0, DONE=0, RESULT=0, state IDLE; a new DIVU 9/3 then returns 3.

Source files
------------

// File: rtl/div_unit_sequencer_if.sv
// Handshake/data bundle between the EX-stage issue logic and the divide sequencer.
interface div_unit_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            div_sel;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, div_sel, data1, data2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, div_sel, data1, data2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit_sequencer.sv
// Radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU with stall (busy) and
// single-cycle resolution of divide-by-zero and signed overflow.
module div_unit_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  div_unit_sequencer_if.slave  bus
);

  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         dvd_q;   // dividend shifts out, quotient bits shift in
  logic [W-1:0]         dvs_q;
  logic [W-1:0]         rem_q;
  logic [1:0]           sel_q;
  logic                 sign1_q;
  logic                 sign2_q;
  logic                 busy_q;
  logic                 done_q;
  logic [W-1:0]         result_q;

  logic         signed_op;
  logic         rem_op;
  logic         div_zero;
  logic         overflow;
  logic [W-1:0] mag1;
  logic [W-1:0] mag2;
  logic [W-1:0] special_res;
  logic [W-1:0] rem_shift;
  logic [W:0]   diff;
  logic         q_bit;
  logic [W-1:0] quo_fix;
  logic [W-1:0] rem_fix;
  logic [W-1:0] fix_res;

  // Operand decode for the accept cycle
  always_comb begin
    signed_op   = ~bus.div_sel[0];
    rem_op      = bus.div_sel[1];
    div_zero    = (bus.data2 == '0);
    overflow    = signed_op && (bus.data1 == {1'b1, {(W-1){1'b0}}}) && (bus.data2 == '1);
    mag1        = (signed_op && bus.data1[W-1]) ? -bus.data1 : bus.data1;
    mag2        = (signed_op && bus.data2[W-1]) ? -bus.data2 : bus.data2;
    special_res = div_zero ? (rem_op ? bus.data1 : '1)
                           : (rem_op ? '0 : bus.data1);
  end

  // One restoring step plus final sign correction
  always_comb begin
    rem_shift = {rem_q[W-2:0], dvd_q[W-1]};
    diff      = {1'b0, rem_shift} - {1'b0, dvs_q};
    q_bit     = ~diff[W];
    quo_fix   = (~sel_q[0] && (sign1_q ^ sign2_q)) ? -dvd_q : dvd_q;
    rem_fix   = (~sel_q[0] && sign1_q) ? -rem_q : rem_q;
    fix_res   = sel_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sel_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              sel_q   <= bus.div_sel;
              sign1_q <= bus.data1[W-1];
              sign2_q <= bus.data2[W-1];
              if (div_zero || overflow) begin
                result_q <= special_res;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                dvd_q   <= mag1;
                dvs_q   <= mag2;
                rem_q   <= '0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= S_CALC;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_CALC: begin
            rem_q <= q_bit ? diff[W-1:0] : rem_shift;
            dvd_q <= {dvd_q[W-2:0], q_bit};
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(W-1)) begin
              state_q <= S_FIX;
            end
          end
          S_FIX: begin
            result_q <= fix_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit_sequencer.sv
// Directed and randomized checks of div_unit_sequencer against an arithmetic model.
module tb_div_unit_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] last_res;

  div_unit_sequencer_if #(.DATA_WIDTH(32)) bus ();

  div_unit_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M reference semantics
  function automatic logic [31:0] model(input logic [1:0] sel, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (sel)
      2'd0:    model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      2'd1:    model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] sel, input logic [31:0] a,
                                    input logic [31:0] b);
    is_special = (b == 0) || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after the accepting edge; returns at the negedge where done=1
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    int lat;
    int bcnt;
    logic [31:0] exp;
    exp        = model(sel, a, b);
    bus.start   = 1'b1;
    bus.div_sel = sel;
    bus.data1   = a;
    bus.data2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check({tag, " result"}, bus.result, exp);
    check({tag, " latency"}, 32'(lat), is_special(sel, a, b) ? 32'd1 : 32'd34);
    check({tag, " busy_cycles"}, 32'(bcnt), is_special(sel, a, b) ? 32'd0 : 32'd33);
    last_res = exp;
  endtask

  initial begin
    int lat;
    int bcnt;
    int dpulses;
    logic [1:0]  rsel;
    logic [31:0] ra;
    logic [31:0] rb;
    checks      = 0;
    errors      = 0;
    last_res    = 32'h0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.div_sel = 2'd0;
    bus.data1   = 32'h0;
    bus.data2   = 32'h0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("divu 100/7", 2'd1, 32'd100, 32'd7);
    @(negedge clk);
    check("done pulse width", 32'(bus.done), 32'd0);
    check("result holds", bus.result, 32'd14);
    do_op("remu 100/7", 2'd3, 32'd100, 32'd7);
    do_op("div -100/7", 2'd0, -32'sd100, 32'd7);
    do_op("rem -100/7", 2'd2, -32'sd100, 32'd7);
    do_op("div 100/-7", 2'd0, 32'd100, -32'sd7);
    do_op("rem 100/-7", 2'd2, 32'd100, -32'sd7);
    do_op("divu 5/0", 2'd1, 32'd5, 32'd0);
    do_op("rem 5/0", 2'd2, 32'd5, 32'd0);
    do_op("div ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu ovf ops", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu big", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Flush mid-operation
    bus.start = 1'b1; bus.div_sel = 2'd1; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush result kept", bus.result, last_res);
    dpulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dpulses++;
    end
    check("flush no done", 32'(dpulses), 32'd0);

    // Back-to-back: start held high into the done cycle with new operands
    bus.start = 1'b1; bus.div_sel = 2'd1; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(negedge clk);
    bus.data1 = 32'd1000; bus.data2 = 32'd3;
    wait_done(lat, bcnt);
    check("b2b first result", bus.result, 32'd14);
    check("b2b first latency", 32'(lat), 32'd34);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b accept busy", 32'(bus.busy), 32'd1);
    wait_done(lat, bcnt);
    check("b2b second result", bus.result, 32'd333);
    check("b2b second latency", 32'(lat), 32'd34);

    // Reset mid-operation
    bus.start = 1'b1; bus.div_sel = 2'd1; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset result", bus.result, 32'h0);
    do_op("divu 9/3", 2'd1, 32'd9, 32'd3);

    // Randomized operations including forced corner operands
    for (int i = 0; i < 30; i++) begin
      rsel = 2'($urandom_range(0, 3));
      ra   = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        4:       begin ra = 32'($urandom_range(0, 50)); rb = $urandom; end
        default: rb = $urandom;
      endcase
      do_op("random", rsel, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
